// File: rtl/serial_sub.sv
// serial_sub: bit-serial N-bit subtractor, O = I0 - I1 - BIN, BOUT = borrow out.
// Subtraction is done as I0 + ~I1 + ~BIN with one full-adder cell reused over
// N cycles, LSB first. Result and borrow are published only when the last bit
// is processed, so O and BOUT never show partial values.
// Ports:
//   CLKIN   clock, rising edge
//   RESETN  synchronous reset, active-low
//   START   request, accepted while idle or in the done cycle
//   I0/I1   minuend/subtrahend, BIN borrow in (sampled on accept)
//   BUSY    high while bits are being processed
//   DONE    one-cycle pulse when O/BOUT update
//   O/BOUT  difference (mod 2^N) and borrow out, held until the next result
module serial_sub #(
  parameter int unsigned N = 8
) (
  input  logic         CLKIN,
  input  logic         RESETN,
  input  logic         START,
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  input  logic         BIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] O,
  output logic         BOUT
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          sum_c;
  logic          carry_c;
  logic [N-1:0]  res_next_c;

  // Full-adder cell on the current bit with the subtrahend inverted.
  // The new sum bit enters at the MSB; taking bits [N:1] of {sum,res} also
  // covers N=1 without a zero-width slice.
  always_comb begin
    sum_c      = a_sr[0] ^ ~b_sr[0] ^ carry;
    carry_c    = (a_sr[0] & ~b_sr[0]) | (a_sr[0] & carry) | (~b_sr[0] & carry);
    res_next_c = N'({sum_c, res_sr} >> 1);
  end

  // Control FSM plus datapath registers; outputs are registered here.
  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      O      <= '0;
      BOUT   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr   <= I0;
            b_sr   <= I1;
            carry  <= ~BIN;  // carry-in of 1 means no borrow
            cnt    <= '0;
            res_sr <= '0;
            BUSY   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_c;
          res_sr <= res_next_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            O     <= res_next_c;
            BOUT  <= ~carry_c;  // no carry out means a borrow occurred
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at N=2 and N=8. The driver pushes the
// expected {BOUT,O} and the cycle the DONE pulse is due; per-instance monitors
// pop and compare whenever DONE is seen.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic       s2, bin2, busy2, done2, bo2;
  logic [1:0] x2, y2, o2;
  logic       s8, bin8, busy8, done8, bo8;
  logic [7:0] x8, y8, o8;

  serial_sub #(.N(2)) u_n2 (
    .CLKIN(clk), .RESETN(rstn), .START(s2), .I0(x2), .I1(y2), .BIN(bin2),
    .BUSY(busy2), .DONE(done2), .O(o2), .BOUT(bo2)
  );

  serial_sub #(.N(8)) u_n8 (
    .CLKIN(clk), .RESETN(rstn), .START(s8), .I0(x8), .I1(y8), .BIN(bin8),
    .BUSY(busy8), .DONE(done8), .O(o8), .BOUT(bo8)
  );

  typedef struct {
    logic [8:0] r;    // {BOUT,O} zero-extended; BOUT at bit N
    int         due;  // cycle count at which DONE must be observed
  } exp_t;

  exp_t q2[$];
  exp_t q8[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: check every DONE pulse against the head of its queue.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) chk("n2_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("n2_o", 32'(o2), 32'(e.r[1:0]));
        chk("n2_bout", 32'(bo2), 32'(e.r[2]));
        chk("n2_latency", 32'(cyc), 32'(e.due));
        chk("n2_busy_at_done", 32'(busy2), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("n8_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("n8_o", 32'(o8), 32'(e.r[7:0]));
        chk("n8_bout", 32'(bo8), 32'(e.r[8]));
        chk("n8_latency", 32'(cyc), 32'(e.due));
        chk("n8_busy_at_done", 32'(busy8), 0);
      end
    end
  end

  // Wait for the selected instance to accept, pulse START, push expectation.
  task automatic issue(input bit wide, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [8:0] er, input bit push);
    int lim;
    exp_t e;
    lim = 0;
    @(negedge clk);
    while ((wide ? busy8 : busy2) && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 100) chk("wait_idle_timeout", 1, 0);
    if (wide) begin
      s8 = 1'b1; x8 = a; y8 = b; bin8 = bin;
    end else begin
      s2 = 1'b1; x2 = a[1:0]; y2 = b[1:0]; bin2 = bin;
    end
    @(negedge clk);
    e.r   = er;
    e.due = cyc + (wide ? 8 : 2);
    if (push) begin
      if (wide) q8.push_back(e);
      else      q2.push_back(e);
    end
    if (wide) s8 = 1'b0;
    else      s2 = 1'b0;
  endtask

  task automatic drain();
    int lim;
    lim = 0;
    while ((q2.size() != 0 || q8.size() != 0) && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 300) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - 9'(bin);
  endfunction

  function automatic logic [8:0] model2(input logic [1:0] a, input logic [1:0] b, input logic bin);
    logic [2:0] r;
    r = {1'b0, a} - {1'b0, b} - 3'(bin);
    return 9'(r);
  endfunction

  initial begin
    int lim;
    exp_t e;
    rstn = 1'b0;
    s2 = 1'b0; x2 = '0; y2 = '0; bin2 = 1'b0;
    s8 = 1'b0; x8 = '0; y8 = '0; bin8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_n2_o", 32'(o2), 0);
    chk("rst_n2_busy", 32'(busy2), 0);
    chk("rst_n2_done", 32'(done2), 0);
    chk("rst_n8_o", 32'(o8), 0);
    chk("rst_n8_bout", 32'(bo8), 0);
    chk("rst_n8_busy", 32'(busy8), 0);
    rstn = 1'b1;

    // Directed N=2 cases.
    issue(1'b0, 8'd3, 8'd1, 1'b0, 9'b0_0000_0010, 1'b1);  // O=2 BOUT=0
    issue(1'b0, 8'd1, 8'd2, 1'b0, 9'b0_0000_0111, 1'b1);  // O=3 BOUT=1
    issue(1'b0, 8'd0, 8'd0, 1'b1, 9'b0_0000_0111, 1'b1);  // O=3 BOUT=1
    issue(1'b0, 8'd2, 8'd2, 1'b0, 9'b0_0000_0000, 1'b1);  // O=0 BOUT=0
    issue(1'b0, 8'd3, 8'd3, 1'b1, 9'b0_0000_0111, 1'b1);  // equal, BIN=1
    drain();

    // Directed N=8 cases.
    issue(1'b1, 8'd200, 8'd55, 1'b0, 9'd145, 1'b1);
    issue(1'b1, 8'd0,   8'd1,  1'b0, 9'h1FF, 1'b1);        // O=255 BOUT=1
    issue(1'b1, 8'd77,  8'd77, 1'b1, 9'h1FF, 1'b1);        // equal, BIN=1
    issue(1'b1, 8'd255, 8'd0,  1'b1, 9'd254, 1'b1);
    drain();

    // Back-to-back with START held high through DONE.
    @(negedge clk);
    s8 = 1'b1; x8 = 8'd200; y8 = 8'd55; bin8 = 1'b0;
    @(negedge clk);
    e.r = 9'd145; e.due = cyc + 8; q8.push_back(e);
    x8 = 8'd10; y8 = 8'd20; bin8 = 1'b1;                   // 10-20-1 -> 245, borrow
    lim = 0;
    while (!done8 && lim < 50) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 50) chk("b2b_done_timeout", 1, 0);
    @(negedge clk);
    chk("b2b_busy_follows_done", 32'(busy8), 1);
    e.r = 9'h1F5; e.due = cyc + 8; q8.push_back(e);
    s8 = 1'b0;
    drain();

    // START and operand changes during RUN are ignored.
    issue(1'b1, 8'd100, 8'd30, 1'b0, 9'd70, 1'b1);
    repeat (3) begin
      s8 = 1'b1; x8 = 8'd5; y8 = 8'd9; bin8 = 1'b1;
      @(negedge clk);
    end
    s8 = 1'b0;
    drain();

    // Reset mid-RUN aborts with no DONE; outputs clear.
    issue(1'b1, 8'd50, 8'd20, 1'b0, 9'd0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_o", 32'(o8), 0);
    chk("midrst_bout", 32'(bo8), 0);
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    repeat (12) @(negedge clk);
    issue(1'b1, 8'd9, 8'd4, 1'b0, 9'd5, 1'b1);
    drain();

    // N=2 exhaustive sweep against the reference model.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          issue(1'b0, 8'(a), 8'(b), 1'(c), model2(2'(a), 2'(b), 1'(c)), 1'b1);
    drain();

    // N=8 random sweep.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      logic       c;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      issue(1'b1, a, b, c, model8(a, b, c), 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
